// File: rtl/button_pkg.sv
// Shared types and constants for the button event decoder and its input stages.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND_HELD
  } state_t;

  // Defaults for a 12 MHz clk
  localparam int LONG_CYCLES_DEF   = 12_000_000;
  localparam int GAP_CYCLES_DEF    = 3_600_000;
  localparam int REPEAT_CYCLES_DEF = 2_400_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Registered copy of a synchronous level plus combinational rise/fall strobes.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

  // q resets low, so a level already high out of reset reads as a rise
  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/short/long/double/auto-repeat pulses.
// The auto-repeat port is repeat_pulse because repeat is a reserved word.
//
// state       | meaning
// IDLE        | button released, nothing pending
// PRESSED     | first press held, timing toward long press
// LONG_HELD   | long press reported, emitting auto-repeat
// WAIT_GAP    | first press released, waiting for a second press
// SECOND_HELD | second press of a double click still held
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click
);

  localparam int CW = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_event_decoder: every cycle parameter must be at least 2");
  end

  logic btn_q, rise, fall;
  state_t state;
  logic [CW-1:0] cnt;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_q),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      press        <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      double_click <= 1'b0;
    end else begin
      press        <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      double_click <= 1'b0;
      cnt          <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (rise) begin
            press <= 1'b1;
            state <= PRESSED;
            cnt   <= '0;
          end
        end
        PRESSED: begin
          // a release on the terminal-count cycle still counts as a short press
          if (fall) begin
            state <= WAIT_GAP;
            cnt   <= '0;
          end else if (cnt == LONG_TC && btn) begin
            long_press <= 1'b1;
            state      <= LONG_HELD;
            cnt        <= '0;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REP_TC) begin
            repeat_pulse <= 1'b1;
            cnt          <= '0;
          end
        end
        WAIT_GAP: begin
          if (rise) begin
            press        <= 1'b1;
            double_click <= 1'b1;
            state        <= SECOND_HELD;
            cnt          <= '0;
          end else if (cnt == GAP_TC) begin
            short_press <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end
        end
        SECOND_HELD: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
